// File: rtl/sync_level_tracker_glitch_filter.sv
// Glitch filter for an already-synchronized control bit: a new level must persist
// FILTER_LEN consecutive cycles before it is accepted into out_data.
module glitch_filter #(
  parameter int unsigned FILTER_LEN = 4,
  parameter logic        RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_data,
  output logic out_data,
  // High in the cycle before out_data changes, so callers can register edge events
  // that line up with the new level.
  output logic out_accept
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            filt_q, filt_d;

  always_comb begin
    cnt_d      = cnt_q;
    filt_d     = filt_q;
    out_accept = 1'b0;
    if (in_data == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      filt_d     = in_data;
      cnt_d      = '0;
      out_accept = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      filt_q <= RESET_VAL;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign out_data = filt_q;

endmodule

// File: rtl/sync_level_tracker.sv
// Filters a synchronized level, emits start/end pulses, measures the start-to-start
// period with saturation and flags loss of the source by timeout.
module sync_level_tracker #(
  parameter logic        POLARITY   = 1'b0,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_level,
  output logic                out_active,
  output logic                out_start,
  output logic                out_end,
  output logic [PERIOD_W-1:0] out_period,
  output logic                out_period_valid,
  output logic                out_timeout
);

  localparam logic [PERIOD_W-1:0] CntMax     = '1;
  localparam logic [PERIOD_W-1:0] TimeoutCnt = PERIOD_W'(TIMEOUT);
  localparam logic                TimeoutEn  = (TIMEOUT != 0);

  logic                filt_raw;
  logic                accept;
  logic                new_active;
  logic                start_q, start_d;
  logic                end_q, end_d;
  logic                armed_q, armed_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PERIOD_W-1:0] period_q, period_d;

  glitch_filter #(
    .FILTER_LEN(FILTER_LEN),
    .RESET_VAL (POLARITY)
  ) u_glitch_filter (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_level),
    .out_data  (filt_raw),
    .out_accept(accept)
  );

  // On accept the filter is about to take in_level, so the new normalized level is known now.
  assign new_active = in_level ^ POLARITY;

  always_comb begin
    start_d   = accept & new_active;
    end_d     = accept & ~new_active;
    cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + PERIOD_W'(1);
    cnt_d     = start_d ? '0 : cnt_inc;
    armed_d   = armed_q | start_d;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    // cnt_inc already is min(counter+1, max), i.e. the saturated period.
    if (start_d && armed_q) begin
      period_d = cnt_inc;
      valid_d  = 1'b1;
    end
    if (start_d) begin
      timeout_d = 1'b0;
    end else if (TimeoutEn && armed_q && (cnt_d == TimeoutCnt)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      armed_q   <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
    end else begin
      start_q   <= start_d;
      end_q     <= end_d;
      armed_q   <= armed_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
    end
  end

  assign out_active       = filt_raw ^ POLARITY;
  assign out_start        = start_q;
  assign out_end          = end_q;
  assign out_period       = period_q;
  assign out_period_valid = valid_q;
  assign out_timeout      = timeout_q;

endmodule

// File: tb/tb_sync_level_tracker.sv
// Directed bench for sync_level_tracker: filter table plus period, timeout, saturation
// and reset sequences across three parameterizations.
module tb_sync_level_tracker;

  logic clk = 1'b0;
  logic rstn;
  logic in_ac;
  logic in_b;

  logic        act_a, st_a, en_a, pv_a, to_a;
  logic [23:0] per_a;
  logic        act_b, st_b, en_b, pv_b, to_b;
  logic [23:0] per_b;
  logic        act_c, st_c, en_c, pv_c, to_c;
  logic [7:0]  per_c;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  always #5 clk = ~clk;

  sync_level_tracker #(
    .POLARITY(1'b0), .FILTER_LEN(4), .PERIOD_W(24), .TIMEOUT(5000)
  ) dut_a (
    .clk(clk), .rstn(rstn), .in_level(in_ac), .out_active(act_a), .out_start(st_a),
    .out_end(en_a), .out_period(per_a), .out_period_valid(pv_a), .out_timeout(to_a)
  );

  sync_level_tracker #(
    .POLARITY(1'b1), .FILTER_LEN(4), .PERIOD_W(24), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .rstn(rstn), .in_level(in_b), .out_active(act_b), .out_start(st_b),
    .out_end(en_b), .out_period(per_b), .out_period_valid(pv_b), .out_timeout(to_b)
  );

  sync_level_tracker #(
    .POLARITY(1'b0), .FILTER_LEN(4), .PERIOD_W(8), .TIMEOUT(0)
  ) dut_c (
    .clk(clk), .rstn(rstn), .in_level(in_ac), .out_active(act_c), .out_start(st_c),
    .out_end(en_c), .out_period(per_c), .out_period_valid(pv_c), .out_timeout(to_c)
  );

  typedef struct packed {
    logic in;
    logic act;
    logic st;
    logic en;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic idle_to(input int t);
    in_ac = 1'b0;
    while (n < t) step();
  endtask

  // Raises in_ac so the filtered start lands exactly at step t (FILTER_LEN = 4).
  task automatic run_to(input int t);
    idle_to(t - 4);
    in_ac = 1'b1;
    repeat (4) step();
    in_ac = 1'b0;
  endtask

  initial begin
    tbl = '{4'b1000, 4'b1000, 4'b1000, 4'b1110, 4'b1100, 4'b0100, 4'b0100, 4'b0100,
            4'b1100, 4'b0100, 4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000,
            4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

    rstn  = 1'b0;
    in_ac = 1'b0;
    in_b  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", 32'({act_a, st_a, en_a, pv_a, to_a, per_a}), 32'd0);
    chk("rst_b", 32'({act_b, st_b, en_b, pv_b, to_b, per_b}), 32'd0);
    chk("rst_c", 32'({act_c, st_c, en_c, pv_c, to_c, per_c}), 32'd0);
    rstn = 1'b1;
    n    = 0;

    // Low-active input
    repeat (3) step();
    chk("b_idle", 32'({act_b, st_b, en_b}), 32'd0);
    in_b = 1'b0;
    repeat (3) step();
    chk("b_pre", 32'({act_b, st_b}), 32'd0);
    step();
    chk("b_start", 32'({act_b, st_b}), 32'b11);
    step();
    chk("b_hold", 32'({act_b, st_b}), 32'b10);

    // Filter latency and glitch rejection
    for (int i = 0; i < 24; i++) begin
      in_ac = tbl[i].in;
      step();
      chk($sformatf("vec%0d", i), 32'({act_a, st_a, en_a}),
          32'({tbl[i].act, tbl[i].st, tbl[i].en}));
    end

    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n    = 0;

    // Period, arming and timeout
    idle_to(5100);
    chk("a_to_unarmed", 32'(to_a), 32'd0);
    run_to(5200);
    chk("a_first_start", 32'({st_a, pv_a, to_a}), 32'b100);
    run_to(6200);
    chk("a_second_start", 32'({st_a, pv_a}), 32'b11);
    chk("a_period1", 32'(per_a), 32'd1000);
    step();
    chk("a_valid_drop", 32'({st_a, pv_a}), 32'b00);
    chk("a_period_hold", 32'(per_a), 32'd1000);
    run_to(7200);
    chk("a_third_valid", 32'(pv_a), 32'd1);
    chk("a_period2", 32'(per_a), 32'd1000);
    idle_to(12199);
    chk("a_to_before", 32'(to_a), 32'd0);
    step();
    chk("a_to_rise", 32'(to_a), 32'd1);
    idle_to(16096);
    chk("a_to_stays", 32'(to_a), 32'd1);
    run_to(16100);
    chk("a_to_clear", 32'({st_a, pv_a, to_a}), 32'b110);
    chk("a_long_period", 32'(per_a), 32'd8900);

    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n    = 0;

    // Saturation and mid-operation reset
    run_to(100);
    chk("c_first", 32'({st_c, pv_c}), 32'b10);
    run_to(400);
    chk("c_sat_valid", 32'(pv_c), 32'd1);
    chk("c_sat_period", 32'(per_c), 32'd255);
    idle_to(650);
    chk("c_no_timeout", 32'(to_c), 32'd0);
    run_to(700);
    chk("c_sat_again", 32'({st_c, pv_c, act_c}), 32'b111);
    in_ac = 1'b1;
    rstn  = 1'b0;
    #1;
    chk("c_async_rst", 32'({act_c, st_c, en_c, pv_c, to_c, per_c}), 32'd0);
    chk("a_async_rst", 32'({act_a, st_a, en_a, pv_a, to_a, per_a}), 32'd0);
    step();
    step();
    chk("c_rst_held", 32'({act_c, st_c, en_c, pv_c, to_c, per_c}), 32'd0);
    rstn = 1'b1;
    n    = 0;
    repeat (3) step();
    chk("c_rel_quiet", 32'({act_c, st_c, en_c, pv_c}), 32'd0);
    step();
    chk("c_rel_start", 32'({act_c, st_c, pv_c}), 32'b110);
    chk("c_rel_period", 32'(per_c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
